// File: rtl/operand_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : operand_loader_if
//  Brief    : Operand switch/pushbutton inputs and captured operand outputs
//             of the operand loader, grouped as one bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface operand_loader_if;
  logic [7:0] SW;      // operand data switches
  logic       Load;    // raw pushbutton, active-low
  logic       Reload;  // qualifies a press in READY
  logic [7:0] A;       // first operand
  logic [7:0] B;       // second operand
  logic       S;       // mux select
  logic       Valid;   // both operands loaded
  logic [1:0] State;   // FSM encoding for LEDs

  // Board / stimulus side
  modport master (output SW, Load, Reload, input A, B, S, Valid, State);
  // Loader side
  modport slave  (input SW, Load, Reload, output A, B, S, Valid, State);
endinterface
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : operand_loader
//  Brief    : Synchronizes and debounces an active-low pushbutton and, on each
//             press, steps a three-state FSM that captures two 8-bit operands
//             from switches and toggles the mux select.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic      Clock,
  input  wire logic      Resetn,
  operand_loader_if.slave bus
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1
  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  // 2'b11 is listed so recovery from it is explicit in the next-state logic
  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    READY   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_deb;
  logic               r_deb_d;
  logic [c_CNT_W-1:0] r_cnt;
  state_t             r_state;
  logic [7:0]         r_a;
  logic [7:0]         r_b;
  logic               r_s;
  logic               r_valid;

  logic               w_press;
  state_t             w_state_nxt;
  logic [7:0]         w_a_nxt;
  logic [7:0]         w_b_nxt;
  logic               w_s_nxt;

  // Two-flop synchronizer for the raw pushbutton; idles high (released)
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.Load;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a level change only after it has persisted long enough
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_deb_d <= r_deb;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_deb <= ~r_deb;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Falling edge of the debounced level is a press; release is ignored
  assign w_press = ~r_deb & r_deb_d;

  // Next state and operand/select updates; everything holds without a press
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_s_nxt     = r_s;
    case (r_state)
      WAIT_A: begin
        if (w_press) begin
          w_a_nxt     = bus.SW;
          w_state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        if (w_press) begin
          w_b_nxt     = bus.SW;
          w_state_nxt = READY;
        end
      end
      READY: begin
        if (w_press) begin
          if (bus.Reload) begin
            w_state_nxt = WAIT_A;
          end else begin
            w_s_nxt = ~r_s;
          end
        end
      end
      default: begin
        // Corrupted encoding: return to WAIT_A without touching operands
        w_state_nxt = WAIT_A;
      end
    endcase
  end

  // State, operand and Valid registers; Valid tracks the registered state
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= WAIT_A;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_s     <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_s     <= w_s_nxt;
      r_valid <= (w_state_nxt == READY);
    end
  end

  assign bus.A     = r_a;
  assign bus.B     = r_b;
  assign bus.S     = r_s;
  assign bus.Valid = r_valid;
  assign bus.State = r_state;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_loader
//  Brief    : Directed, self-checking bench for operand_loader with a
//             scoreboard of expected post-press outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_loader;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [1:0] st;
    logic       v;
  } exp_t;

  localparam exp_t c_RESET = '{a: 8'h00, b: 8'h00, s: 1'b0, st: 2'b00, v: 1'b0};

  logic Clock;
  logic Resetn;
  int   n_vec;
  int   n_err;
  exp_t m;        // reference model of the outputs
  exp_t q[$];     // scoreboard of pending press results

  operand_loader_if bus ();

  operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".A"},     32'(bus.A),     32'(e.a));
    check({tag, ".B"},     32'(bus.B),     32'(e.b));
    check({tag, ".S"},     32'(bus.S),     32'(e.s));
    check({tag, ".State"}, 32'(bus.State), 32'(e.st));
    check({tag, ".Valid"}, 32'(bus.Valid), 32'(e.v));
  endtask

  // Model of one accepted press applied to the current expected outputs
  function automatic exp_t apply_press(input exp_t cur, input logic [7:0] sw, input logic rl);
    exp_t e;
    e = cur;
    case (cur.st)
      2'b00: begin e.a = sw; e.st = 2'b01; end
      2'b01: begin e.b = sw; e.st = 2'b10; end
      2'b10: begin if (rl) e.st = 2'b00; else e.s = ~cur.s; end
      default: e.st = 2'b00;
    endcase
    e.v = (e.st == 2'b10);
    return e;
  endfunction

  // Pop the scoreboard head and compare it with the DUT outputs
  task automatic pop_compare(input string tag);
    exp_t e;
    n_vec++;
    assert (q.size() != 0) else begin
      n_err++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      check_all(tag, e);
      m = e;
    end
  endtask

  // Hold Load low for 'hold' cycles, check action lands exactly on edge 7,
  // then release and confirm release produces no action.
  task automatic press(input string tag, input logic [7:0] sw, input logic rl, input int hold);
    q.push_back(apply_press(m, sw, rl));
    @(negedge Clock);
    bus.SW = sw; bus.Reload = rl; bus.Load = 1'b0;
    repeat (6) @(posedge Clock);
    #1 check({tag, ".early"}, 32'(bus.State), 32'(m.st));
    @(posedge Clock);
    #1 pop_compare(tag);
    repeat (hold - 7) @(posedge Clock);
    @(negedge Clock);
    bus.Load = 1'b1; bus.SW = 8'($urandom);
    repeat (12) @(posedge Clock);
    #1 check_all({tag, ".rel"}, m);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m     = c_RESET;
    Resetn     = 1'b0;
    bus.SW     = 8'($urandom);
    bus.Load   = 1'($urandom);
    bus.Reload = 1'b0;

    // Reset values visible before any clock edge, then held while clocked
    #2 check_all("rst_async", c_RESET);
    repeat (3) begin
      @(negedge Clock);
      bus.SW = 8'($urandom); bus.Load = 1'($urandom);
    end
    @(posedge Clock);
    #1 check_all("rst_hold", c_RESET);
    @(negedge Clock);
    bus.Load = 1'b1; Resetn = 1'b1;
    repeat (3) @(posedge Clock);

    // First operand capture, held 10 cycles
    press("capA_3C", 8'h3C, 1'b0, 10);

    // Short glitch: 3 cycles low then 10 high must do nothing
    @(negedge Clock);
    bus.Load = 1'b0; bus.SW = 8'hAA;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    bus.Load = 1'b1;
    repeat (10) @(posedge Clock);
    #1 check_all("glitch", m);

    // Complete the pair, go back, and load 11/F0
    press("capB_F0", 8'hF0, 1'b0, 8);
    press("reload0", 8'h77, 1'b1, 9);
    press("capA_11", 8'h11, 1'b0, 8);
    press("capB_F0b", 8'hF0, 1'b0, 20);
    press("tog1", 8'h00, 1'b0, 8);
    press("tog0", 8'hFF, 1'b0, 8);
    press("tog1b", 8'h5A, 1'b0, 8);
    press("reload1", 8'h66, 1'b1, 8);
    press("capA_22", 8'h22, 1'b0, 8);

    // Reset two cycles into a held press while in WAIT_B
    @(negedge Clock);
    bus.Load = 1'b0; bus.SW = 8'h99;
    repeat (2) @(posedge Clock);
    #2 Resetn = 1'b0;
    #1 check_all("rst_mid", c_RESET);
    m = c_RESET;
    repeat (3) begin
      @(negedge Clock);
      bus.SW = 8'($urandom); bus.Load = 1'($urandom);
    end
    @(posedge Clock);
    #1 check_all("rst_mid_hold", c_RESET);
    @(negedge Clock);
    bus.Load = 1'b1; Resetn = 1'b1;
    repeat (15) @(posedge Clock);
    #1 check_all("rst_mid_after", c_RESET);

    // Load held low across reset release counts as a fresh press
    @(negedge Clock);
    Resetn = 1'b0; bus.Load = 1'b0; bus.SW = 8'h5A; bus.Reload = 1'b0;
    q.push_back(apply_press(m, 8'h5A, 1'b0));
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (6) @(posedge Clock);
    #1 check("held_rst.early", 32'(bus.State), 32'(m.st));
    @(posedge Clock);
    #1 pop_compare("held_rst");
    @(negedge Clock);
    bus.Load = 1'b1;
    repeat (12) @(posedge Clock);
    #1 check_all("held_rst.rel", m);

    check("sb_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
